// File: rtl/mem_block_mover.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_block_mover : block copy / block fill initiator for a single-port memory
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_block_mover #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [AW:0]      length,
  input  logic [WIDTH-1:0] fill_value,
  output logic             busy,
  output logic             done,
  output logic             mem_enable,
  output logic             mem_write_enable,
  output logic [AW-1:0]    mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] LEN_MAX  = CW'(DEPTH);
  localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    src_ptr_q;
  logic [AW-1:0]    dst_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] fill_q;
  logic             busy_q;
  logic             done_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;

  logic [AW-1:0]    src_ptr_d;
  logic [AW-1:0]    dst_ptr_d;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    len_d;
  logic             last_word;

  // Addresses wrap modulo DEPTH even when DEPTH is not a power of two.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == ADDR_TOP) ? '0 : p + AW'(1);
  endfunction

  assign src_ptr_d = wrap_inc(src_ptr_q);
  assign dst_ptr_d = wrap_inc(dst_ptr_q);
  assign count_d   = count_q - CW'(1);
  assign last_word = (count_q == CW'(1));
  assign len_d     = (length > LEN_MAX) ? LEN_MAX : length;

  // Outputs are loaded alongside the state they belong to, so every memory
  // strobe comes straight from a flop. mem_wdata_q doubles as the copy buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      count_q     <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            src_ptr_q <= src_addr;
            dst_ptr_q <= dst_addr;
            count_q   <= len_d;
            fill_q    <= fill_value;
            busy_q    <= 1'b1;
            if (len_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!mode) begin
              state_q    <= S_READ;
              mem_en_q   <= 1'b1;
              mem_addr_q <= src_addr;
            end else begin
              state_q     <= S_FILL;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= dst_addr;
              mem_wdata_q <= fill_value;
            end
          end
        end
        S_READ: begin
          state_q     <= S_WRITE;
          mem_en_q    <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= dst_ptr_q;
          mem_wdata_q <= mem_rdata;
        end
        S_WRITE: begin
          src_ptr_q <= src_ptr_d;
          dst_ptr_q <= dst_ptr_d;
          count_q   <= count_d;
          if (last_word) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_READ;
            mem_en_q   <= 1'b1;
            mem_addr_q <= src_ptr_d;
          end
        end
        S_FILL: begin
          dst_ptr_q <= dst_ptr_d;
          count_q   <= count_d;
          if (last_word) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= dst_ptr_d;
            mem_wdata_q <= fill_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_enable       = mem_en_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;

endmodule
`default_nettype wire
